// File: rtl/convcor_sched.sv
// Scheduler that arbitrates two requesters onto one shared CONVCOR engine.
// It streams three sample beats per job and forwards result beats, with a stall timeout.
module convcor_sched #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic        req0_mode,
    input  logic        req1_mode,
    input  logic [47:0] req0_a,
    input  logic [47:0] req1_a,
    input  logic [47:0] req0_b,
    input  logic [47:0] req1_b,
    output logic        eng_in_valid,
    output logic [15:0] eng_in_a,
    output logic [15:0] eng_in_b,
    output logic        eng_in_mode,
    input  logic        eng_out_valid,
    input  logic [35:0] eng_out,
    output logic        res_valid,
    output logic        res_id,
    output logic [35:0] res_data,
    output logic        res_last,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, COLLECT} state_t;

    typedef struct packed {
        logic        id;
        logic        mode;
        logic [47:0] a;
        logic [47:0] b;
    } job_t;

    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

    state_t      state_q, state_d;
    job_t        job_q;
    logic        prio_q;
    logic [1:0]  beat_q;
    logic [2:0]  rem_q;
    logic [4:0]  tcnt_q;

    logic        gnt0, gnt1, active, fwd, last, tmo;
    logic [15:0] smp_a, smp_b;

    // Arbitration: a lone requester wins outright, a tie goes to the pointer.
    assign gnt0 = (state_q == IDLE) && req0_valid && (!req1_valid || !prio_q);
    assign gnt1 = (state_q == IDLE) && req1_valid && (!req0_valid ||  prio_q);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign active = (state_q == WAIT) || (state_q == COLLECT);
    assign fwd    = active && eng_out_valid;
    assign last   = fwd && (rem_q == 3'd1);
    assign tmo    = active && !eng_out_valid && (tcnt_q == TMO_LAST);

    always_comb begin
        smp_a = job_q.a[15:0];
        smp_b = job_q.b[15:0];
        case (beat_q)
            2'd1: begin
                smp_a = job_q.a[31:16];
                smp_b = job_q.b[31:16];
            end
            2'd2: begin
                smp_a = job_q.a[47:32];
                smp_b = job_q.b[47:32];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt0 || gnt1) state_d = SEND;
            SEND:    if (beat_q == 2'd2) state_d = WAIT;
            WAIT: begin
                if (last || tmo) state_d = IDLE;
                else if (fwd)    state_d = COLLECT;
            end
            COLLECT: if (last || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            job_q   <= '0;
            prio_q  <= 1'b0;
            beat_q  <= 2'd0;
            rem_q   <= 3'd0;
            tcnt_q  <= 5'd0;
        end else begin
            state_q <= state_d;

            if (gnt0 || gnt1) begin
                job_q  <= gnt1 ? job_t'{1'b1, req1_mode, req1_a, req1_b}
                               : job_t'{1'b0, req0_mode, req0_a, req0_b};
                prio_q <= gnt0;
                rem_q  <= (gnt1 ? req1_mode : req0_mode) ? 3'd1 : 3'd5;
            end else if (fwd) begin
                rem_q  <= rem_q - 3'd1;
            end

            beat_q <= (state_q == SEND) ? beat_q + 2'd1 : 2'd0;

            // Counter is held at zero through SEND so WAIT always starts fresh.
            if (active && !eng_out_valid)
                tcnt_q <= tcnt_q + 5'd1;
            else
                tcnt_q <= 5'd0;
        end
    end

    assign eng_in_valid = (state_q == SEND);
    assign eng_in_a     = eng_in_valid ? smp_a : 16'd0;
    assign eng_in_b     = eng_in_valid ? smp_b : 16'd0;
    assign eng_in_mode  = eng_in_valid ? job_q.mode : 1'b0;

    assign res_valid = fwd;
    assign res_data  = fwd ? eng_out : 36'd0;
    assign res_last  = last;
    assign err       = tmo;
    assign res_id    = (fwd || tmo) ? job_q.id : 1'b0;

endmodule

// File: tb/tb_convcor_sched.sv
// Self-checking bench for convcor_sched: an engine stub plus a scoreboard of
// expected result/error beats filled when jobs are issued.
module tb_convcor_sched;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic        req0_mode, req1_mode;
    logic [47:0] req0_a, req1_a, req0_b, req1_b;
    logic        eng_in_valid, eng_in_mode;
    logic [15:0] eng_in_a, eng_in_b;
    logic        eng_out_valid;
    logic [35:0] eng_out;
    logic        res_valid, res_id, res_last, err;
    logic [35:0] res_data;

    convcor_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_mode(req0_mode), .req1_mode(req1_mode),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .eng_in_valid(eng_in_valid), .eng_in_a(eng_in_a), .eng_in_b(eng_in_b),
        .eng_in_mode(eng_in_mode), .eng_out_valid(eng_out_valid), .eng_out(eng_out),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_last(res_last), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          id;
        logic [35:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [35:0] eng_q[$];
    exp_t        e;
    int          checks = 0, failures = 0;
    bit          stall = 0, spur = 0;
    int          gap_after = -1, gap_left = 0, emitted = 0;
    int          cap_n = 0, wcnt = 0, run = 0;
    logic [15:0] cap_a[3], cap_b[3];
    logic        cap_mode;

    localparam logic [47:0] A123 = {16'h0300, 16'h0200, 16'h0100};
    localparam logic [47:0] B111 = {16'h0100, 16'h0100, 16'h0100};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sre(input logic [47:0] v, input int k);
        logic [15:0] s;
        logic signed [7:0] r;
        s = v[16*k +: 16];
        r = s[15:8];
        return int'(r);
    endfunction

    function automatic int sim(input logic [47:0] v, input int k);
        logic [15:0] s;
        logic signed [7:0] r;
        s = v[16*k +: 16];
        r = s[7:0];
        return int'(r);
    endfunction

    // Complex convolution beat n, or the single correlation sum a*conj(b).
    function automatic logic [35:0] model(input bit mode, input logic [47:0] a, input logic [47:0] b, input int n);
        int re = 0, im = 0;
        for (int k = 0; k < 3; k++) begin
            if (mode) begin
                re += sre(a, k) * sre(b, k) + sim(a, k) * sim(b, k);
                im += sim(a, k) * sre(b, k) - sre(a, k) * sim(b, k);
            end else if (n - k >= 0 && n - k <= 2) begin
                re += sre(a, k) * sre(b, n - k) - sim(a, k) * sim(b, n - k);
                im += sre(a, k) * sim(b, n - k) + sim(a, k) * sre(b, n - k);
            end
        end
        return {18'(re), 18'(im)};
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    task automatic push_job(input bit id, input bit mode, input logic [47:0] a, input logic [47:0] b);
        int cnt = mode ? 1 : 5;
        for (int n = 0; n < cnt; n++)
            exp_q.push_back('{1'b0, id, model(mode, a, b, n), n == cnt - 1});
    endtask

    task automatic submit(input bit id, input bit mode, input logic [47:0] a, input logic [47:0] b);
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1; req1_mode = mode; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1; req0_mode = mode; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                @(posedge clk); #1;
                req0_valid = 0; req1_valid = 0;
                return;
            end
        end
        chk("grant_timeout", id ? req1_ready : req0_ready, 1);
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor at negedge, engine stub drives just after posedge.
    initial begin
        eng_out_valid = 0;
        eng_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap_n = 0; run = 0; emitted = 0; gap_left = 0;
                eng_q.delete();
            end else if (eng_in_valid) begin
                if (cap_n == 0) cap_mode = eng_in_mode;
                else chk("eng_mode_stable", eng_in_mode, cap_mode);
                cap_a[cap_n] = eng_in_a;
                cap_b[cap_n] = eng_in_b;
                cap_n++; run++; wcnt = 0;
                if (cap_n == 3) begin
                    for (int n = 0; n < (cap_mode ? 1 : 5); n++)
                        eng_q.push_back(model(cap_mode, {cap_a[2], cap_a[1], cap_a[0]},
                                              {cap_b[2], cap_b[1], cap_b[0]}, n));
                    cap_n = 0; emitted = 0;
                end
            end else begin
                chk("eng_idle_zero", {eng_in_a, eng_in_b, eng_in_mode}, 0);
                if (run > 0) chk("send_len", run, 3);
                run = 0;
                wcnt++;
            end

            if (res_valid || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {res_valid, err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_kind", {err, res_valid}, {e.is_err, !e.is_err});
                    chk("res_id", res_id, e.id);
                    if (e.is_err) begin
                        chk("err_cycle", wcnt, TIMEOUT);
                        eng_q.delete();
                    end else begin
                        chk("res_data", res_data, e.data);
                        chk("res_last", res_last, e.last);
                    end
                end
            end else begin
                chk("idle_res_zero", {res_data, res_last}, 0);
            end

            @(posedge clk); #1;
            eng_out_valid = 0;
            eng_out = {4'($urandom()), 32'($urandom())};
            if (spur) begin
                eng_out_valid = 1;
                spur = 0;
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (!stall && eng_q.size() != 0) begin
                eng_out_valid = 1;
                eng_out = eng_q.pop_front();
                emitted++;
                if (emitted == gap_after) gap_left = 2;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1;
        req0_valid = 0; req1_valid = 0; req0_mode = 0; req1_mode = 0;
        req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {eng_in_valid, res_valid, res_last, err, res_id, res_data,
                            req0_ready, req1_ready}, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_ready0", req0_ready, 1);
        chk("rst_ready1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
        rst = 0;

        // Convolution of (1,2,3) with (1,1,1) from requester 0.
        exp_q.push_back('{1'b0, 1'b0, {18'd1, 18'd0}, 1'b0});
        exp_q.push_back('{1'b0, 1'b0, {18'd3, 18'd0}, 1'b0});
        exp_q.push_back('{1'b0, 1'b0, {18'd6, 18'd0}, 1'b0});
        exp_q.push_back('{1'b0, 1'b0, {18'd5, 18'd0}, 1'b0});
        exp_q.push_back('{1'b0, 1'b0, {18'd3, 18'd0}, 1'b1});
        submit(0, 0, A123, B111);
        drain("drain_conv");

        // Correlation from requester 1.
        exp_q.push_back('{1'b0, 1'b1, {18'd6, 18'd0}, 1'b1});
        submit(1, 1, A123, B111);
        drain("drain_corr");

        // Both requesters held valid: grants must alternate starting at 0.
        begin
            logic [47:0] a0, b0, a1, b1;
            int g = 0;
            a0 = rnd48(); b0 = rnd48(); a1 = rnd48(); b1 = rnd48();
            for (int j = 0; j < 4; j++) begin
                if (j % 2 == 0) push_job(0, 0, a0, b0);
                else            push_job(1, 1, a1, b1);
            end
            @(posedge clk); #1;
            req0_valid = 1; req0_mode = 0; req0_a = a0; req0_b = b0;
            req1_valid = 1; req1_mode = 1; req1_a = a1; req1_b = b1;
            for (int c = 0; c < 400 && g < 4; c++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    chk("ready_onehot", {req0_ready, req1_ready}, (g % 2) ? 2'b01 : 2'b10);
                    g++;
                end
            end
            chk("grant_count", g, 4);
            @(posedge clk); #1;
            req0_valid = 0; req1_valid = 0;
            drain("drain_alt");
        end

        // Engine stall: timeout abort, then the next job runs normally.
        stall = 1;
        exp_q.push_back('{1'b1, 1'b1, 36'd0, 1'b0});
        submit(1, 0, rnd48(), rnd48());
        drain("drain_tmo");
        stall = 0;
        begin
            logic [47:0] a, b;
            a = rnd48(); b = rnd48();
            push_job(0, 1, a, b);
            submit(0, 1, a, b);
            drain("drain_after_tmo");
        end

        // Reset during the second SEND beat of a requester-0 job.
        submit(0, 0, rnd48(), rnd48());
        @(posedge clk); #1;
        chk("send_before_rst", eng_in_valid, 1);
        rst = 1;
        #1;
        chk("rst_drops_send", {eng_in_valid, err, res_last}, 0);
        @(posedge clk); #1;
        rst = 0;
        begin
            logic [47:0] a, b;
            a = rnd48(); b = rnd48();
            push_job(0, 1, a, b);
            req0_valid = 1; req0_mode = 1; req0_a = a; req0_b = b;
            req1_valid = 1; req1_mode = 0; req1_a = rnd48(); req1_b = rnd48();
            @(negedge clk);
            chk("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
            @(posedge clk); #1;
            req0_valid = 0; req1_valid = 0;
            drain("drain_post_rst");
        end

        // Spurious engine beats in IDLE and SEND, plus a 2-cycle gap mid-COLLECT.
        spur = 1;
        repeat (3) @(negedge clk);
        gap_after = 2;
        begin
            logic [47:0] a, b;
            a = rnd48(); b = rnd48();
            push_job(1, 0, a, b);
            submit(1, 0, a, b);
            spur = 1;
            drain("drain_gap");
        end
        gap_after = -1;

        // A few random back-to-back jobs.
        for (int j = 0; j < 4; j++) begin
            logic [47:0] a, b;
            bit id, mode;
            a = rnd48(); b = rnd48();
            id = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            push_job(id, mode, a, b);
            submit(id, mode, a, b);
            drain("drain_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
